// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with level/pulse interrupt.
// Register map (addr[3:2]): 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (ro), 3 reserved.
// Optional feature macro: TC_AUTO_RELOAD_EN enables MODE=1 periodic reload with a
// one-cycle irq pulse. Without it, MODE is not stored and every expiry is one-shot.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | stopped; waits for EN=1
// LOAD  | copies PRESET into COUNT
// CNT   | decrements COUNT to 0 while EN=1; EN=0 stops and holds COUNT
// INT   | expiry cycle; one-shot clears EN, periodic keeps it for reload
module timer_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   en_q, en_d;
    logic                   im_q, im_d;
    logic [CNT_WIDTH-1:0]   preset_q, preset_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   irq_flag_q, irq_flag_d;
    logic                   irq_q, irq_d;
    logic [1:0]             mode_rd;
    logic                   periodic;
`ifdef TC_AUTO_RELOAD_EN
    logic [1:0]             mode_q, mode_d;
`endif

    logic [1:0]             sel;
    logic                   wr_any;
    logic                   wr_ctrl_any;
    logic                   wr_ctrl_lane0;
    logic                   wr_preset;
    logic [31:0]            preset_wr_data;
    logic                   unused_bits;

    assign sel           = addr[3:2];
    assign wr_any        = we && (byteen != 4'b0000);
    assign wr_ctrl_any   = wr_any && (sel == 2'd0);
    assign wr_ctrl_lane0 = we && byteen[0] && (sel == 2'd0);
    assign wr_preset     = wr_any && (sel == 2'd1);
    assign unused_bits   = ^{addr[31:4], addr[1:0], preset_wr_data};

`ifdef TC_AUTO_RELOAD_EN
    assign mode_rd  = mode_q;
    assign periodic = (mode_q == 2'd1);
`else
    assign mode_rd  = 2'b00;
    assign periodic = 1'b0;
`endif

    // Combinational read mux; unused high bits of narrow counters read 0.
    always_comb begin
        rdata = 32'h0;
        case (sel)
            2'd0:    rdata = {28'h0, im_q, mode_rd, en_q};
            2'd1:    rdata = 32'(preset_q);
            2'd2:    rdata = 32'(count_q);
            default: rdata = 32'h0;
        endcase
    end

    // Next-state logic: FSM first, then CPU writes override so a CTRL write beats the INT EN clear.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        en_d       = en_q;
        im_d       = im_q;
        preset_d   = preset_q;
        irq_flag_d = irq_flag_q;
`ifdef TC_AUTO_RELOAD_EN
        mode_d     = mode_q;
`endif

        preset_wr_data = 32'(preset_q);
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                preset_wr_data[8*i +: 8] = wdata[8*i +: 8];
            end
        end

        if (wr_ctrl_any || wr_preset) begin
            irq_flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_WIDTH'(1);
                end else begin
                    state_d    = ST_INT;
                    irq_flag_d = 1'b1;
                end
            end
            ST_INT: begin
                if (periodic) begin
                    irq_flag_d = 1'b0;
                end else begin
                    en_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_ctrl_lane0) begin
            en_d = wdata[0];
            im_d = wdata[3];
`ifdef TC_AUTO_RELOAD_EN
            mode_d = wdata[2:1];
`endif
        end
        if (wr_preset) begin
            preset_d = preset_wr_data[CNT_WIDTH-1:0];
        end

        irq_d = irq_flag_d && im_d;
    end

    // State and register file flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
`ifdef TC_AUTO_RELOAD_EN
            mode_q     <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
`ifdef TC_AUTO_RELOAD_EN
            mode_q     <= mode_d;
`endif
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter; edge numbering follows E0 = edge writing EN=1.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [3:0]  byteen = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_counter #(.CNT_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    // Write applied on the next rising edge; returns 1ns after that edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr = a; wdata = d; byteen = be; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0;
        #12;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), d);
            n_vec++;
            if (d !== 32'h0) begin
                $display("FAIL reset_read_%0d: got %h expected %h", i, d, 32'h0);
                n_err++;
            end
        end
        n_vec++;
        if (irq !== 1'b0) begin
            $display("FAIL reset_irq: got %b expected 0", irq);
            n_err++;
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d;
        wr(32'h4, 32'hFFFF_FFFF, 4'hF);
        wr(32'h4, 32'h0000_0012, 4'h1);
        rd(32'h4, d);
        n_vec++;
        if (d !== 32'hFFFF_FF12) begin
            $display("FAIL lane0_preset: got %h expected %h", d, 32'hFFFF_FF12);
            n_err++;
        end
        wr(32'h4, 32'h0000_0034, 4'h0);
        rd(32'h4, d);
        n_vec++;
        if (d !== 32'hFFFF_FF12) begin
            $display("FAIL byteen0_preset: got %h expected %h", d, 32'hFFFF_FF12);
            n_err++;
        end
        wr(32'h4, 32'h00AB_0000, 4'h4);
        rd(32'h4, d);
        n_vec++;
        if (d !== 32'hFFAB_FF12) begin
            $display("FAIL lane2_preset: got %h expected %h", d, 32'hFFAB_FF12);
            n_err++;
        end
        wr(32'h8, 32'h0000_0055, 4'hF);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL count_write_ignored: got %h expected %h", d, 32'h0);
            n_err++;
        end
        wr(32'hC, 32'hFFFF_FFFF, 4'hF);
        rd(32'hC, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL reserved_read: got %h expected %h", d, 32'h0);
            n_err++;
        end
        rd(32'h4, d);
        n_vec++;
        if (d !== 32'hFFAB_FF12) begin
            $display("FAIL reserved_write_preset: got %h expected %h", d, 32'hFFAB_FF12);
            n_err++;
        end
        wr(32'h0, 32'hFFFF_FFF0, 4'hF);
        rd(32'h0, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL ctrl_upper_bits: got %h expected %h", d, 32'h0);
            n_err++;
        end
    endtask

    task automatic test_one_shot;
        logic [31:0] d;
        wr(32'h4, 32'd5, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(2);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'd5) begin
            $display("FAIL oneshot_count_e2: got %0d expected 5", d);
            n_err++;
        end
        for (int e = 3; e <= 7; e++) begin
            tick(1);
            rd(32'h8, d);
            n_vec++;
            if (d !== 32'(7 - e)) begin
                $display("FAIL oneshot_count_e%0d: got %0d expected %0d", e, d, 7 - e);
                n_err++;
            end
        end
        n_vec++;
        if (irq !== 1'b0) begin
            $display("FAIL oneshot_irq_e7: got %b expected 0", irq);
            n_err++;
        end
        tick(1);
        n_vec++;
        if (irq !== 1'b1) begin
            $display("FAIL oneshot_irq_e8: got %b expected 1", irq);
            n_err++;
        end
        tick(1);
        rd(32'h0, d);
        n_vec++;
        if (d !== 32'h8) begin
            $display("FAIL oneshot_ctrl_e9: got %h expected %h", d, 32'h8);
            n_err++;
        end
        tick(3);
        n_vec++;
        if (irq !== 1'b1) begin
            $display("FAIL oneshot_irq_held: got %b expected 1", irq);
            n_err++;
        end
        wr(32'h4, 32'd5, 4'hF);
        n_vec++;
        if (irq !== 1'b0) begin
            $display("FAIL oneshot_irq_cleared: got %b expected 0", irq);
            n_err++;
        end
    endtask

    task automatic test_periodic;
        logic [31:0] d;
        logic        exp;
        wr(32'h4, 32'd2, 4'hF);
        wr(32'h0, 32'hB, 4'hF);
        rd(32'h0, d);
`ifdef TC_AUTO_RELOAD_EN
        n_vec++;
        if (d !== 32'hB) begin
            $display("FAIL periodic_ctrl_readback: got %h expected %h", d, 32'hB);
            n_err++;
        end
        for (int k = 1; k <= 18; k++) begin
            tick(1);
            exp = (k == 5) || (k == 11) || (k == 17);
            n_vec++;
            if (irq !== exp) begin
                $display("FAIL periodic_irq_e%0d: got %b expected %b", k, irq, exp);
                n_err++;
            end
        end
`else
        n_vec++;
        if (d !== 32'h9) begin
            $display("FAIL mode_not_stored: got %h expected %h", d, 32'h9);
            n_err++;
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp = (k >= 5);
            n_vec++;
            if (irq !== exp) begin
                $display("FAIL mode1_as_oneshot_irq_e%0d: got %b expected %b", k, irq, exp);
                n_err++;
            end
            if (k == 6) begin
                rd(32'h0, d);
                n_vec++;
                if (d !== 32'h8) begin
                    $display("FAIL mode1_as_oneshot_ctrl: got %h expected %h", d, 32'h8);
                    n_err++;
                end
            end
        end
        wr(32'h4, 32'd2, 4'hF);
`endif
        wr(32'h0, 32'h0, 4'hF);
        tick(4);
    endtask

    task automatic test_mask_stop;
        logic [31:0] d;
        wr(32'h4, 32'd3, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        tick(5);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL mask_count_e5: got %0d expected 0", d);
            n_err++;
        end
        tick(1);
        n_vec++;
        if (irq !== 1'b0) begin
            $display("FAIL mask_irq_e6: got %b expected 0", irq);
            n_err++;
        end
        tick(1);
        rd(32'h0, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL mask_en_cleared: got %h expected %h", d, 32'h0);
            n_err++;
        end
    endtask

    task automatic test_hold;
        logic [31:0] d;
        wr(32'h4, 32'd20, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        tick(14);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'd8) begin
            $display("FAIL hold_count_e14: got %0d expected 8", d);
            n_err++;
        end
        wr(32'h0, 32'h0, 4'hF);
        tick(3);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'd7) begin
            $display("FAIL hold_count_held: got %0d expected 7", d);
            n_err++;
        end
        wr(32'h0, 32'h1, 4'hF);
        tick(2);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'd20) begin
            $display("FAIL hold_reload: got %0d expected 20", d);
            n_err++;
        end
        wr(32'h0, 32'h0, 4'hF);
        tick(4);
    endtask

    task automatic test_simultaneous;
        logic [31:0] d;
        wr(32'h4, 32'd3, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        tick(6);
        wr(32'h0, 32'h1, 4'hF);
        rd(32'h0, d);
        n_vec++;
        if (d !== 32'h1) begin
            $display("FAIL simul_ctrl_wins: got %h expected %h", d, 32'h1);
            n_err++;
        end
        tick(2);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'd3) begin
            $display("FAIL simul_restart_count: got %0d expected 3", d);
            n_err++;
        end
        wr(32'h0, 32'h0, 4'hF);
        tick(4);
    endtask

    task automatic test_reset_async;
        logic [31:0] d;
        wr(32'h4, 32'd50, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        tick(10);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'd42) begin
            $display("FAIL async_count_before: got %0d expected 42", d);
            n_err++;
        end
        #2;
        reset = 1'b0;
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL async_count_zeroed: got %0d expected 0", d);
            n_err++;
        end
        @(negedge clk);
        reset = 1'b1;
        tick(4);
        rd(32'h8, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL async_no_resume: got %0d expected 0", d);
            n_err++;
        end
        wr(32'h4, 32'd0, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(3);
        n_vec++;
        if (irq !== 1'b1) begin
            $display("FAIL preset0_irq_e3: got %b expected 1", irq);
            n_err++;
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (irq !== 1'b0) begin
            $display("FAIL async_irq_zeroed: got %b expected 0", irq);
            n_err++;
        end
        rd(32'h0, d);
        n_vec++;
        if (d !== 32'h0) begin
            $display("FAIL async_ctrl_zeroed: got %h expected %h", d, 32'h0);
            n_err++;
        end
        @(negedge clk);
        reset = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_one_shot();
        test_periodic();
        test_mask_stop();
        test_hold();
        test_simultaneous();
        test_reset_async();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped down-counting timer on the CPU data bus, downstream of the pipeline's M stage. It consumes `m_data_addr`, `m_data_wdata` and `m_data_byteen` after system-bridge address decode, and returns read data combinationally so the W-stage register captures it in the same cycle. It raises a level interrupt request when the count expires. Two modes: one-shot, and auto-reload periodic.

## Interface
- `CNT_WIDTH`, default 32: width of PRESET and COUNT. Valid range is 2..32; bits above `CNT_WIDTH` read 0.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; 0 forces the reset state immediately.
- `addr` input 32: byte address from the bridge; only `addr[3:2]` is decoded.
- `we` input 1: write strobe, already qualified by the bridge's chip-select.
- `byteen` input 4: byte-lane enables; lane i writes `wdata[8i+7:8i]`.
- `wdata` input 32: write data.
- `rdata` output 32: combinational read data.
- `irq` output 1: interrupt request, registered.

## Operation
- Register map, selected by `addr[3:2]`:
  - 0: CTRL. bit0 EN, bits2:1 MODE, bit3 IM; bits 31:4 read 0 and ignore writes.
  - 1: PRESET, read/write.
  - 2: COUNT, read-only; writes are ignored.
  - 3: reserved; reads 0, writes ignored.
- Writes apply per enabled byte lane on the clock edge where `we`=1. `byteen`=0 writes nothing.
- State machine, with state updated each edge:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE and hold COUNT. Else if COUNT≠0, COUNT <= COUNT−1 and stay in CNT. Else (COUNT=0) go to INT and set `irq_flag`.
  - INT, MODE=0: clear EN; go to IDLE.
  - INT, MODE=1: keep EN; go to IDLE, which then reloads from PRESET.
- MODE values 2 and 3 behave as MODE 0.
- `irq` = `irq_flag` AND IM, registered.
  - MODE 0: `irq_flag` stays set until any write to CTRL or PRESET.
  - MODE 1: `irq_flag` is set only during the INT cycle, giving a one-cycle pulse.
- Simultaneous events:
  - A CPU write to CTRL on the same edge as the INT-state update of EN: the CPU write wins.
  - A write clearing `irq_flag` on the same edge it would be set: set wins.
- A PRESET write during CNT does not change COUNT; it takes effect at the next LOAD.
- COUNT never wraps: decrement happens only when COUNT≠0.

## Timing
- Reset values: `rdata` = decode of zeroed registers, which is 0. `irq`=0, state IDLE, CTRL=PRESET=COUNT=0, `irq_flag`=0.
- `rdata` is purely combinational from `addr` and current register state. A write is visible on reads from the cycle after its edge.
- Edges are numbered relative to E0, the edge that writes EN=1:
  - E1: LOAD.
  - E2: COUNT=PRESET.
  - E(2+PRESET): COUNT=0.
  - E(3+PRESET): INT; `irq` high after this edge.
- MODE 1 period is PRESET+4 cycles between `irq` pulses.
- A reset assertion mid-count zeroes everything asynchronously. Counting resumes only after software sets EN again.

## Configuration
- `TC_AUTO_RELOAD_EN` defined: MODE=1 periodic reload and one-cycle `irq` pulse, exactly as in Operation.
- `TC_AUTO_RELOAD_EN` undefined:
  - MODE bits are not stored and read back 0.
  - Every expiry behaves as MODE 0.
  - The MODE-1 irq-pulse logic is absent.

## Test plan
- Reset: deassert `reset` and read addresses 0x0, 0x4, 0x8, 0xC. Required response: all return 0 and `irq`=0. Then assert `reset` mid-count; COUNT and `irq` must go to 0 immediately without waiting for a clock edge.
- One-shot: PRESET=5, then CTRL=0x9 at E0. Required response:
  - COUNT reads 5,4,3,2,1,0 after E2..E7.
  - `irq` rises after E8; CTRL reads 0x8 after E9.
  - `irq` stays high until PRESET is written, then falls next edge.
- Periodic (macro defined): PRESET=2, CTRL=0xB. Required response: `irq` is high for exactly one cycle after E5, E11 and E17.
- Byte lanes: PRESET=0xFFFFFFFF, then write 0x00000012 with `byteen`=0001. Required response: PRESET reads 0xFFFFFF12. A write to COUNT or to address 0xC changes nothing.
- Masking and stop:
  - CTRL=0x1 with PRESET=3: COUNT reaches 0, `irq` stays 0, and EN clears.
  - Clearing EN mid-count at COUNT=7 holds COUNT=7 in IDLE; re-enabling reloads from PRESET.
- Simultaneous write: write CTRL=0x1 on the same edge as the MODE-0 INT-state EN clear. Required response: EN reads 1 afterwards.
